// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed driver for a bank of common-anode 7-segment digits.
//   Each digit owns one scan slot of COUNT_PERIOD cycles, split into 16 phases
//   of COUNT_PERIOD/16 cycles. The anode of the current digit is lit during
//   phases 1..brightness (phase 0 is a dark guard against ghosting while the
//   cathodes change). New digit values arrive on a valid/ready port, wait in
//   a pending register and are promoted to the displayed set only at a frame
//   boundary, so a frame never mixes old and new values.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   val_in          hex nibbles, digit i = val_in[4i+3:4i]
//   digit_en_in     per-digit enable, captured together with val_in
//   val_valid_in    load request
//   val_ready_out   load port can accept (pending register empty)
//   brightness_in   0 = dark, 15 = 15/16 duty; sampled at each slot start
//   cat_out         segment cathodes, active-low, bit0 = a .. bit6 = g
//   an_out          digit anodes, active-low
//   frame_done_out  one-cycle pulse in the last cycle of the last slot

// Hex to 7-segment decoder, active-high segments, bit0 = a .. bit6 = g.
module seg7_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
endmodule

module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    val_valid_in,
  output logic                    val_ready_out,
  input  logic [3:0]              brightness_in,
  output logic [6:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);
  localparam int SUB   = COUNT_PERIOD / 16;
  localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Timing chain: sub-count -> phase -> digit index.
  logic [SUB_W-1:0] sub_reg;
  logic [3:0]       phase_reg;
  logic [DIG_W-1:0] digit_reg;

  logic sub_last, phase_last, digit_last, frame_done, slot_start;

  assign sub_last   = (sub_reg == SUB_W'(SUB - 1));
  assign phase_last = (phase_reg == 4'd15);
  assign digit_last = (digit_reg == DIG_W'(NUM_DIGITS - 1));
  assign frame_done = sub_last && phase_last && digit_last;
  assign slot_start = (sub_reg == '0) && (phase_reg == 4'd0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sub_reg   <= '0;
      phase_reg <= 4'd0;
      digit_reg <= '0;
    end else if (sub_last) begin
      sub_reg <= '0;
      if (phase_last) begin
        phase_reg <= 4'd0;
        digit_reg <= digit_last ? '0 : digit_reg + 1'b1;
      end else begin
        phase_reg <= phase_reg + 4'd1;
      end
    end else begin
      sub_reg <= sub_reg + 1'b1;
    end
  end

  // Brightness is frozen for the whole slot so every digit gets a clean duty.
  logic [3:0] slot_bright_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_bright_reg <= 4'd0;
    end else if (slot_start) begin
      slot_bright_reg <= brightness_in;
    end
  end

  // Load path: pending holds one accepted request until the next boundary.
  logic [4*NUM_DIGITS-1:0] pending_val_reg, active_val_reg;
  logic [NUM_DIGITS-1:0]   pending_en_reg, active_en_reg;
  logic                    pending_full_reg;
  logic                    accept;

  // accept and the boundary promotion are exclusive: promotion needs a full
  // pending register, which holds ready low.
  assign accept = val_valid_in && !pending_full_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_val_reg  <= '0;
      pending_en_reg   <= '0;
      active_val_reg   <= '0;
      active_en_reg    <= '0;
      pending_full_reg <= 1'b0;
    end else if (accept) begin
      pending_val_reg  <= val_in;
      pending_en_reg   <= digit_en_in;
      pending_full_reg <= 1'b1;
    end else if (frame_done && pending_full_reg) begin
      active_val_reg   <= pending_val_reg;
      active_en_reg    <= pending_en_reg;
      pending_full_reg <= 1'b0;
    end
  end

  // Per-digit nibble view and anode selection.
  logic [3:0]            nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_next;
  logic                  lit;

  // Phase 0 stays dark regardless of brightness.
  assign lit = (phase_reg != 4'd0) && (phase_reg <= slot_bright_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi]  = active_val_reg[4*gi +: 4];
      assign an_next[gi] = !((digit_reg == DIG_W'(gi)) && active_en_reg[gi] && lit);
    end
  endgenerate

  logic [6:0] cur_seg;

  seg7_hex_decoder u_decoder (
    .hex (nibble[digit_reg]),
    .seg (cur_seg)
  );

  // Registered outputs: cathodes and anodes move on the same edge.
  logic [6:0]            cat_reg;
  logic [NUM_DIGITS-1:0] an_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cat_reg <= 7'h7F;
      an_reg  <= '1;
    end else begin
      cat_reg <= ~cur_seg;
      an_reg  <= an_next;
    end
  end

  assign cat_out        = cat_reg;
  assign an_out         = an_reg;
  assign frame_done_out = frame_done;
  assign val_ready_out  = !pending_full_reg;

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexed driver for a bank of common-anode 7-segment digits.
- Each digit gets a fixed scan slot; the controller decodes the digit's 4-bit hex nibble through the existing hex-to-7-segment decoder (one shared instance) and drives active-low cathodes and anodes.
- Adds per-digit enable, 16-level brightness PWM with an anti-ghosting guard, and a valid/ready load port whose values are applied only at frame boundaries.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes scanned.
- COUNT_PERIOD, 100000, clock cycles per digit slot; must be a multiple of 16 and at least 16.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- val_in  in  4*NUM_DIGITS  hex nibbles; digit i = val_in[4i+3:4i]
- digit_en_in  in  NUM_DIGITS  per-digit enable, captured with val_in
- val_valid_in  in  1  load request
- val_ready_out  out  1  load port can accept
- brightness_in  in  4  0 = dark, 15 = max duty
- cat_out  out  7  segment cathodes, active-low, bit0 = seg a … bit6 = seg g
- an_out  out  NUM_DIGITS  digit anodes, active-low
- frame_done_out  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (async assert, sync release):
  - an_out = all 1s, cat_out = 7'h7F, frame_done_out = 0, val_ready_out = 1.
  - Active and pending registers cleared (values 0, enables 0).
  - Scan position = digit 0, phase 0, sub-count 0.
  - Reset mid-frame aborts the frame; scanning restarts at digit 0.
- Timing chain:
  - SUB = COUNT_PERIOD/16. The sub-counter counts 0..SUB-1.
  - On wrap, phase (0..15) increments. On phase 15 wrap, digit index increments (0..NUM_DIGITS-1, then back to 0).
  - Frame = NUM_DIGITS*COUNT_PERIOD cycles.
- Slot:
  - brightness_in is sampled into a slot register on the first cycle of each slot (phase 0, sub 0); mid-slot changes have no effect.
  - Anode of the current digit is driven low iff the digit is enabled AND 1 <= phase <= slot_brightness.
  - Phase 0 is always dark (guard). Brightness 0 keeps the digit dark for the whole slot; brightness 15 gives 15/16 duty.
  - All other anodes stay high.
- Segments: cat_out = bitwise NOT of the decoder output for the current digit's active nibble.
- Output registers: cat_out and an_out are registered, 1-cycle latency from the scan counters. The cathode and anode for a slot change on the same edge.
- Disabled digits still consume their slot (constant refresh rate); their anode stays high.
- Load handshake:
  - Transfer occurs when val_valid_in && val_ready_out on a rising edge; val_in and digit_en_in are captured into the pending register.
  - val_ready_out = !pending_full (registered flag).
  - At a frame boundary (the cycle frame_done_out is high), if pending_full: pending is copied to active and pending_full clears. val_ready_out therefore returns high on the following cycle.
  - A valid arriving on the boundary cycle with pending empty is captured to pending. It is not bypassed to active; it is applied at the next boundary.
  - A valid while pending is full is not accepted; the source holds it.
- frame_done_out: high for exactly the last cycle of digit NUM_DIGITS-1, phase 15, sub SUB-1. Not asserted while in reset.
- Active values change only at frame boundaries, so no torn frames.

Test Plan:
Bench parameters: NUM_DIGITS=4, COUNT_PERIOD=32 (SUB=2, slot 32 cycles, frame 128 cycles).
1. Assert rst_n_in low mid-slot while an_out=4'b1110 -> an_out=4'hF, cat_out=7'h7F, val_ready_out=1 without a clock edge. After release, frame_done_out first pulses on cycle 128.
2. Load val_in=16'h1A3F, digit_en_in=4'hF, brightness_in=15 -> applied after the next frame_done_out.
   - Digit 0 slot: an_out=4'hF for 2 cycles, then 4'b1110 for 30 cycles, cat_out=7'h0E.
   - Digit 1 slot: an_out=4'b1101, cat_out=7'h30.
3. brightness_in=4 -> the enabled anode is low for exactly 8 cycles per slot (phases 1-4). brightness_in=0 -> an_out stays 4'hF. A change mid-slot takes effect only from the next slot.
4. digit_en_in=4'b0101 -> an_out[1] and an_out[3] never go low. Slot timing and frame_done_out spacing (128 cycles) are unchanged.
5. Back-to-back valids A then B:
   - A is accepted and val_ready_out drops the next cycle; B is held.
   - A is displayed after the boundary. val_ready_out rises one cycle after frame_done_out, B is accepted, and B is displayed one frame later.
6. Valid on the exact frame_done_out cycle with pending empty -> value is captured, not displayed that frame, and shown starting after the following boundary.
